// File: rtl/adc_sar_pkg.sv
// Shared types and constants for the 12-bit SAR ADC sequencer.
package adc_sar_pkg;

  localparam int ADC_BITS     = 12;
  localparam int SAMPLE_LEN_W = 4;
  localparam logic [ADC_BITS-1:0] ADC_CODE_RESET = 12'h000;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    TRIAL,
    COMP,
    DONE
  } state_t;

endpackage

// File: rtl/adc_sar_reg.sv
// Successive-approximation register: decided bits plus the bit currently under trial.
module adc_sar_reg #(
  parameter int ADC_BITS = 12,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                set_trial,
  input  logic                decide,
  input  logic [IDX_W-1:0]    bit_idx,
  input  logic                comp_in,
  output logic [ADC_BITS-1:0] code
);

  logic [ADC_BITS-1:0] decided;
  logic [ADC_BITS-1:0] trial_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decided <= '0;
    end else if (clear) begin
      decided <= '0;
    end else if (decide) begin
      decided[bit_idx] <= comp_in;
    end
  end

  // Trial bit is decoded from the registered index, so code stays register-driven.
  always_comb begin
    trial_mask = '0;
    if (set_trial) trial_mask[bit_idx] = 1'b1;
  end

  assign code = decided | trial_mask;

endmodule

// File: rtl/adc_sar_controller.sv
// SAR conversion sequencer: sample phase, MSB-first bit trials, result publish.
module adc_sar_controller #(
  parameter int ADC_BITS = adc_sar_pkg::ADC_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [adc_sar_pkg::SAMPLE_LEN_W-1:0] sample_len,
  input  logic                                 comp_in,
  output logic [ADC_BITS-1:0]                  data,
  output logic                                 sample,
  output logic                                 comp_trig,
  output logic                                 busy,
  output logic [ADC_BITS-1:0]                  result,
  output logic                                 conv_finished
);

  import adc_sar_pkg::*;

  localparam int IDX_W = $clog2(ADC_BITS);
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(ADC_BITS - 1);
  localparam logic [SAMPLE_LEN_W-1:0] ONE_LEN = SAMPLE_LEN_W'(1);

  state_t                  state, state_next;
  logic [IDX_W-1:0]        bit_idx;
  logic [SAMPLE_LEN_W-1:0] s_len;
  logic [SAMPLE_LEN_W-1:0] cnt;
  logic                    accept;
  logic                    sar_clear;
  logic                    sar_set_trial;
  logic                    sar_decide;

  assign accept = ((state == IDLE) || (state == DONE)) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SAMPLE;
      SAMPLE:  if (cnt == s_len - ONE_LEN) state_next = TRIAL;
      TRIAL:   state_next = COMP;
      COMP:    state_next = (bit_idx == '0) ? DONE : TRIAL;
      DONE:    state_next = start ? SAMPLE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sample        = (state == SAMPLE);
    comp_trig     = (state == COMP);
    busy          = (state == SAMPLE) || (state == TRIAL) || (state == COMP);
    conv_finished = (state == DONE);
    sar_clear     = (state == IDLE) || (state == DONE);
    sar_set_trial = (state == TRIAL) || (state == COMP);
    sar_decide    = (state == COMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_len   <= ONE_LEN;
      cnt     <= '0;
      bit_idx <= MSB_IDX;
      result  <= ADC_BITS'(ADC_CODE_RESET);
    end else begin
      if (accept) begin
        s_len <= (sample_len == '0) ? ONE_LEN : sample_len;
        cnt   <= '0;
      end
      if (state == SAMPLE) begin
        cnt <= cnt + ONE_LEN;
        if (cnt == s_len - ONE_LEN) bit_idx <= MSB_IDX;
      end
      if (state == COMP) begin
        if (bit_idx != '0) bit_idx <= bit_idx - IDX_W'(1);
        // Final code takes the last decision directly so result is valid in DONE.
        else result <= {data[ADC_BITS-1:1], comp_in};
      end
    end
  end

  adc_sar_reg #(
    .ADC_BITS (ADC_BITS),
    .IDX_W    (IDX_W)
  ) u_sar_reg (
    .clk       (clk),
    .rst       (rst),
    .clear     (sar_clear),
    .set_trial (sar_set_trial),
    .decide    (sar_decide),
    .bit_idx   (bit_idx),
    .comp_in   (comp_in),
    .code      (data)
  );

endmodule

// File: tb/tb_adc_sar_controller.sv
// Bench for adc_sar_controller: comparator model plus cycle-level expectation model.
module tb_adc_sar_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  sample_len = '0;
  logic        comp_in;
  logic [11:0] data;
  logic        sample;
  logic        comp_trig;
  logic        busy;
  logic [11:0] result;
  logic        conv_finished;

  logic [11:0] vin = '0;
  int          cmode = 0;   // 0 ideal comparator, 1 tied high, 2 tied low
  logic [11:0] last_result = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign comp_in = (cmode == 0) ? (vin >= data) : (cmode == 1);

  adc_sar_controller #(.ADC_BITS(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sample_len    (sample_len),
    .comp_in       (comp_in),
    .data          (data),
    .sample        (sample),
    .comp_trig     (comp_trig),
    .busy          (busy),
    .result        (result),
    .conv_finished (conv_finished)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".data"}, data, 0);
    check({tag, ".result"}, result, 0);
    check({tag, ".sample"}, sample, 0);
    check({tag, ".comp_trig"}, comp_trig, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".conv_finished"}, conv_finished, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle.busy", busy, 0);
      check("idle.sample", sample, 0);
      check("idle.data", data, 0);
      check("idle.fin", conv_finished, 0);
      check("idle.result", result, last_result);
    end
  endtask

  // Expected waveform derived from the cycle numbering after the accepting edge:
  // SAMPLE 1..S, bit k TRIAL/COMP at S+1+2(11-k)/S+2+2(11-k), DONE at S+25.
  task automatic run_conv(input logic [11:0] v, input int mode, input logic [3:0] slen,
                          input bit hold, input int pulse_c, input int abort_c);
    int s, j, k, fi;
    logic [11:0] f, ed;
    s  = (slen == 0) ? 1 : int'(slen);
    f  = (mode == 0) ? v : (mode == 1) ? 12'hFFF : 12'h000;
    fi = int'(f);
    vin = v;
    cmode = mode;
    sample_len = slen;
    start = 1'b1;
    for (int c = 1; c <= s + 25; c++) begin
      @(negedge clk);
      j = c - s - 1;
      k = 11 - j / 2;
      if (c <= s) ed = '0;
      else if (c <= s + 24) ed = 12'(((fi >> (k + 1)) << (k + 1)) | (1 << k));
      else ed = f;
      if (c == s + 25) last_result = f;
      check("data", data, ed);
      check("sample", sample, c <= s);
      check("comp_trig", comp_trig, (c > s) && (c <= s + 24) && (j % 2 == 1));
      check("busy", busy, c <= s + 24);
      check("conv_finished", conv_finished, c == s + 25);
      check("result", result, last_result);
      if (c == abort_c) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        #1;
        rst = 1'b0;
        start = 1'b0;
        last_result = '0;
        return;
      end
      if (c < s + 25) sample_len = 4'($urandom);
      if (c == 1) start = hold;
      if (c == pulse_c) start = 1'b1;
      else if (c == pulse_c + 1) start = hold;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    run_conv(12'hA5C, 0, 4'd4, 1'b0, -1, -1);
    idle_cycles(2);
    run_conv(12'($urandom), 1, 4'd7, 1'b0, -1, -1);
    run_conv(12'($urandom), 2, 4'd2, 1'b0, -1, -1);
    idle_cycles(1);
    run_conv(12'($urandom), 0, 4'd0, 1'b0, -1, -1);
    idle_cycles(1);

    // back-to-back with start held
    run_conv(12'h001, 0, 4'd4, 1'b1, -1, -1);
    run_conv(12'h800, 0, 4'd4, 1'b1, -1, -1);
    run_conv(12'hFFE, 0, 4'd4, 1'b0, -1, -1);
    idle_cycles(2);

    // start pulsed during COMP of bit 7 (cycle S+10)
    run_conv(12'($urandom), 0, 4'd3, 1'b0, 13, -1);
    idle_cycles(3);

    // reset during TRIAL of bit 6 (cycle S+11)
    run_conv(12'($urandom), 0, 4'd5, 1'b0, -1, 16);
    idle_cycles(1);
    run_conv(12'h123, 0, 4'd2, 1'b0, -1, -1);
    idle_cycles(1);

    for (int n = 0; n < 10; n++) begin
      run_conv(12'($urandom), (n % 4 == 3) ? int'($urandom_range(1, 2)) : 0,
               4'($urandom), 1'($urandom), -1, -1);
      start = 1'b0;
      idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
